ff_bank_multimode: RTL and testbench

//   Parametrised bank of WIDTH edge-triggered storage bits. Run-time mode select picks
//   D, T, SR or JK next-state behaviour for all bits.

---
 rtl/ff_bank_multimode.sv | 116 +++++++++++
 tb/tb_ff_bank_multimode.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ff_bank_multimode.sv
// Bank of WIDTH clocked storage bits with run-time D/T/SR/JK behaviour,
// synchronous load, per-bit change detect and SR conflict reporting.
module ff_bank_multimode #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               SR_POLICY = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             flag_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic [WIDTH-1:0] changed,
  output logic [WIDTH-1:0] conflict_mask,
  output logic             sr_conflict
);

  typedef enum logic [1:0] {
    M_D  = 2'b00,
    M_T  = 2'b01,
    M_SR = 2'b10,
    M_JK = 2'b11
  } mode_e;

  mode_e mode_s;
  assign mode_s = mode_e'(mode);

  logic [WIDTH-1:0] set_m;
  logic [WIDTH-1:0] clr_m;
  logic [WIDTH-1:0] both_m;

  assign set_m  = a & ~b;
  assign clr_m  = ~a & b;
  assign both_m = a & b;

  logic [WIDTH-1:0] d_nx;
  logic [WIDTH-1:0] t_nx;
  logic [WIDTH-1:0] sr_base;
  logic [WIDTH-1:0] sr_nx;
  logic [WIDTH-1:0] jk_nx;

  assign d_nx    = a;
  assign t_nx    = q ^ a;
  assign sr_base = (q & ~clr_m) | set_m;
  assign jk_nx   = (a & ~q) | (~b & q);

  // S=R=1 bits keep q in sr_base; the policy only overrides those bits.
  always_comb begin
    sr_nx = sr_base;
    if (SR_POLICY == 1) begin
      sr_nx = sr_base | both_m;
    end else if (SR_POLICY == 2) begin
      sr_nx = sr_base & ~both_m;
    end
  end

  logic [WIDTH-1:0] mode_nx;
  logic [WIDTH-1:0] mode_cm;

  always_comb begin
    mode_nx = q;
    mode_cm = '0;
    unique case (mode_s)
      M_D:  mode_nx = d_nx;
      M_T:  mode_nx = t_nx;
      M_SR: begin
        mode_nx = sr_nx;
        mode_cm = both_m;
      end
      M_JK: mode_nx = jk_nx;
      default: mode_nx = q;
    endcase
  end

  logic [WIDTH-1:0] q_nx;
  logic [WIDTH-1:0] cm_nx;

  always_comb begin
    q_nx  = q;
    cm_nx = '0;
    if (load) begin
      q_nx = load_val;
    end else if (en) begin
      q_nx  = mode_nx;
      cm_nx = mode_cm;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q             <= RESET_VAL;
      qn            <= ~RESET_VAL;
      changed       <= '0;
      conflict_mask <= '0;
      sr_conflict   <= 1'b0;
    end else begin
      q             <= q_nx;
      qn            <= ~q_nx;
      changed       <= q_nx ^ q;
      conflict_mask <= cm_nx;
      // a fresh conflict outranks a same-edge clear
      if (|cm_nx) begin
        sr_conflict <= 1'b1;
      end else if (flag_clr) begin
        sr_conflict <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ff_bank_multimode.sv
// Bench for ff_bank_multimode: three instances (SR_POLICY 0/1/2)
// checked every cycle against a bit-level model plus literal vectors.
module tb_ff_bank_multimode;

  localparam int W = 4;
  localparam logic [W-1:0] RV = 4'b0101;

  logic         clk = 1'b0;
  logic         rst, en, load, flag_clr;
  logic [1:0]   mode;
  logic [W-1:0] a, b, load_val;

  logic [W-1:0] q [3];
  logic [W-1:0] qn [3];
  logic [W-1:0] ch [3];
  logic [W-1:0] cm [3];
  logic         sc [3];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ff_bank_multimode #(.WIDTH(W), .RESET_VAL(RV), .SR_POLICY(0)) u0 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b),
    .load(load), .load_val(load_val), .flag_clr(flag_clr),
    .q(q[0]), .qn(qn[0]), .changed(ch[0]),
    .conflict_mask(cm[0]), .sr_conflict(sc[0])
  );
  ff_bank_multimode #(.WIDTH(W), .RESET_VAL(RV), .SR_POLICY(1)) u1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b),
    .load(load), .load_val(load_val), .flag_clr(flag_clr),
    .q(q[1]), .qn(qn[1]), .changed(ch[1]),
    .conflict_mask(cm[1]), .sr_conflict(sc[1])
  );
  ff_bank_multimode #(.WIDTH(W), .RESET_VAL(RV), .SR_POLICY(2)) u2 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b),
    .load(load), .load_val(load_val), .flag_clr(flag_clr),
    .q(q[2]), .qn(qn[2]), .changed(ch[2]),
    .conflict_mask(cm[2]), .sr_conflict(sc[2])
  );

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
    end
  endtask

  // model state per instance
  logic [W-1:0] mq [3];
  logic [W-1:0] mch [3];
  logic [W-1:0] mcm [3];
  logic         msc [3];
  bit           started = 0;

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      logic [W-1:0] nq;
      logic [W-1:0] ncm;
      nq  = mq[k];
      ncm = '0;
      if (rst) begin
        nq = RV;
      end else if (load) begin
        nq = load_val;
      end else if (en) begin
        for (int i = 0; i < W; i++) begin
          case (mode)
            2'd0: nq[i] = a[i];
            2'd1: nq[i] = mq[k][i] ^ a[i];
            2'd2: begin
              if (a[i] && !b[i]) nq[i] = 1'b1;
              else if (!a[i] && b[i]) nq[i] = 1'b0;
              else if (a[i] && b[i]) begin
                ncm[i] = 1'b1;
                if (k == 1) nq[i] = 1'b1;
                else if (k == 2) nq[i] = 1'b0;
              end
            end
            default: begin
              if (a[i] && b[i]) nq[i] = !mq[k][i];
              else if (a[i]) nq[i] = 1'b1;
              else if (b[i]) nq[i] = 1'b0;
            end
          endcase
        end
      end
      if (rst) begin
        mch[k] = '0;
        msc[k] = 1'b0;
      end else begin
        mch[k] = nq ^ mq[k];
        if (ncm != 0) msc[k] = 1'b1;
        else if (flag_clr) msc[k] = 1'b0;
      end
      mcm[k] = ncm;
      mq[k]  = nq;
    end
    if (rst) started = 1;
    #1;
    if (started) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("m%0d.q", k), q[k], mq[k]);
        chk($sformatf("m%0d.qn", k), qn[k], ~mq[k]);
        chk($sformatf("m%0d.changed", k), ch[k], mch[k]);
        chk($sformatf("m%0d.cmask", k), cm[k], mcm[k]);
        chk($sformatf("m%0d.sticky", k), {3'b0, sc[k]}, {3'b0, msc[k]});
      end
    end
  end

  task automatic step(input logic r, input logic ld, input logic [W-1:0] lv,
                      input logic e, input logic [1:0] md,
                      input logic [W-1:0] aa, input logic [W-1:0] bb,
                      input logic fc);
    @(negedge clk);
    rst = r; load = ld; load_val = lv; en = e; mode = md;
    a = aa; b = bb; flag_clr = fc;
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 0; en = 0; load = 0; flag_clr = 0;
    mode = 2'd0; a = '0; b = '0; load_val = '0;
    for (int k = 0; k < 3; k++) begin
      mq[k] = '0; mch[k] = '0; mcm[k] = '0; msc[k] = 0;
    end

    // 1. reset
    step(1, 0, 4'h0, 0, 2'd0, 4'h0, 4'h0, 0);
    step(0, 0, 4'h0, 0, 2'd0, 4'h0, 4'h0, 0);
    chk("rst.q", q[0], 4'b0101);
    chk("rst.qn", qn[0], 4'b1010);
    chk("rst.changed", ch[0], 4'b0000);
    chk("rst.sticky", {3'b0, sc[0]}, 4'b0000);

    // 2. D mode then hold
    step(0, 0, 4'h0, 1, 2'd0, 4'b1100, 4'h0, 0);
    chk("d.q", q[0], 4'b1100);
    chk("d.changed", ch[0], 4'b1001);
    step(0, 0, 4'h0, 0, 2'd0, 4'b0011, 4'h0, 0);
    chk("hold.q", q[0], 4'b1100);
    chk("hold.changed", ch[0], 4'b0000);

    // 3. T mode twice from 0101
    step(0, 1, 4'b0101, 0, 2'd0, 4'h0, 4'h0, 0);
    chk("load.changed", ch[0], 4'b1001);
    step(0, 0, 4'h0, 1, 2'd1, 4'b1111, 4'h0, 0);
    chk("t1.q", q[0], 4'b1010);
    chk("t1.changed", ch[0], 4'b1111);
    step(0, 0, 4'h0, 1, 2'd1, 4'b1111, 4'h0, 0);
    chk("t2.q", q[0], 4'b0101);
    chk("t2.changed", ch[0], 4'b1111);

    // 4. SR with conflict on all policies
    step(0, 1, 4'b0000, 0, 2'd0, 4'h0, 4'h0, 0);
    step(0, 0, 4'h0, 1, 2'd2, 4'b0011, 4'b0110, 0);
    chk("sr.q.p0", q[0], 4'b0001);
    chk("sr.q.p1", q[1], 4'b0011);
    chk("sr.q.p2", q[2], 4'b0001);
    chk("sr.cmask", cm[0], 4'b0010);
    chk("sr.cmask.p1", cm[1], 4'b0010);
    chk("sr.sticky", {3'b0, sc[0]}, 4'b0001);
    step(0, 0, 4'h0, 0, 2'd2, 4'h0, 4'h0, 0);
    chk("sr.keep.sticky", {3'b0, sc[0]}, 4'b0001);
    chk("sr.keep.cmask", cm[0], 4'b0000);
    step(0, 0, 4'h0, 1, 2'd2, 4'h0, 4'h0, 1);
    chk("clr.sticky", {3'b0, sc[0]}, 4'b0000);
    chk("clr.q", q[0], 4'b0001);
    step(0, 0, 4'h0, 1, 2'd2, 4'b0010, 4'b0010, 1);
    chk("setwins.sticky", {3'b0, sc[0]}, 4'b0001);

    // D ignores undefined b; immediate mode switch to T
    step(0, 0, 4'h0, 1, 2'd0, 4'b0110, 4'bxxxx, 0);
    chk("dx.q", q[0], 4'b0110);
    chk("dx.changed", ch[0], 4'b0111);
    step(0, 0, 4'h0, 1, 2'd1, 4'b0011, 4'bxxxx, 0);
    chk("tx.q", q[0], 4'b0101);

    // 5. JK
    step(0, 1, 4'b0101, 0, 2'd0, 4'h0, 4'h0, 0);
    step(0, 0, 4'h0, 1, 2'd3, 4'b1111, 4'b1100, 0);
    chk("jk.q", q[0], 4'b1011);
    chk("jk.cmask", cm[0], 4'b0000);

    // 6. reset beats load and en
    step(1, 1, 4'b1001, 1, 2'd3, 4'b1111, 4'b1100, 0);
    chk("rstwin.q", q[0], 4'b0101);
    chk("rstwin.sticky", {3'b0, sc[0]}, 4'b0000);
    chk("rstwin.changed", ch[0], 4'b0000);
    step(0, 1, 4'b1001, 1, 2'd3, 4'b1111, 4'b1100, 0);
    chk("ld.q", q[0], 4'b1001);
    chk("ld.changed", ch[0], 4'b1100);

    step(0, 0, 4'h0, 0, 2'd0, 4'h0, 4'h0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
